// File: rtl/mux_rr_sequencer_pkg.sv
// Shared definitions for the mux round-robin sequencer: FSM state
// encoding, channel count, select width and a select-to-one-hot helper.
package mux_rr_sequencer_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_WAIT    = 2'd2
   } state_t;

   function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
      logic [NUM_CH-1:0] oh;
      oh    = '0;
      oh[s] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mux_rr_sequencer_if.sv
// Bus between the sequencer and its surroundings: channel requests and
// grants, the mux select/return path and the downstream valid/ready output.
interface mux_rr_sequencer_if
   import mux_rr_sequencer_pkg::*;
#(
   parameter int DATA_W = 4
);
   logic [NUM_CH-1:0] req;
   logic [DATA_W-1:0] mux_out;
   logic [SEL_W-1:0]  sel;
   logic [NUM_CH-1:0] gnt;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   // sequencer side
   modport master (
      input  req, mux_out, out_ready,
      output sel, gnt, out_data, out_valid
   );

   // channels / mux / downstream side
   modport slave (
      output req, mux_out, out_ready,
      input  sel, gnt, out_data, out_valid
   );
endinterface

// File: rtl/mux_rr_sequencer_rr_pick4.sv
// Combinational winner finder: first requesting channel scanning from
// i_ptr upward with 2-bit wrap. o_any is low when nobody requests.
module rr_pick4
   import mux_rr_sequencer_pkg::*;
(
   input  logic [NUM_CH-1:0] i_req,
   input  logic [SEL_W-1:0]  i_ptr,
   output logic [SEL_W-1:0]  o_winner,
   output logic              o_any
);

   // scan highest offset first so the nearest requester overwrites last
   always_comb begin
      logic [SEL_W-1:0] w_idx;
      o_winner = i_ptr;
      o_any    = |i_req;
      for (int k = NUM_CH-1; k >= 0; k--) begin
         w_idx = i_ptr + SEL_W'(k);
         if (i_req[w_idx]) o_winner = w_idx;
      end
   end

endmodule

// File: rtl/mux_rr_sequencer.sv
// Round-robin sequencer in front of a 4x1 mux: picks a channel, drives
// sel, captures mux_out one cycle later and offers it over valid/ready.
// Build option: define FIXED_PRIO_EN to hold the pointer at 0, giving
// fixed priority with channel 0 highest.
module mux_rr_sequencer
   import mux_rr_sequencer_pkg::*;
#(
   parameter int               DATA_W  = 4,
   parameter logic [SEL_W-1:0] PTR_RST = '0
) (
   input logic                clk,
   input logic                rst,
   mux_rr_sequencer_if.master bus
);

`ifdef FIXED_PRIO_EN
   localparam logic [SEL_W-1:0] PTR_INIT = '0;
`else
   localparam logic [SEL_W-1:0] PTR_INIT = PTR_RST;
`endif

   state_t            r_state, w_state_nxt;
   logic [SEL_W-1:0]  r_ptr, w_ptr_nxt;
   logic [SEL_W-1:0]  r_sel, w_sel_nxt;
   logic [NUM_CH-1:0] r_gnt, w_gnt_nxt;
   logic [DATA_W-1:0] r_data, w_data_nxt;
   logic              r_valid, w_valid_nxt;
   logic [SEL_W-1:0]  w_winner;
   logic              w_any;

   rr_pick4 u_pick (
      .i_req    (bus.req),
      .i_ptr    (r_ptr),
      .o_winner (w_winner),
      .o_any    (w_any)
   );

   // next-state and register updates; gnt defaults low so it only pulses
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_sel_nxt   = r_sel;
      w_gnt_nxt   = '0;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_sel_nxt   = w_winner;
               w_state_nxt = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            // unconditional: requesters hold req/data until their gnt
            w_data_nxt  = bus.mux_out;
            w_valid_nxt = 1'b1;
            w_gnt_nxt   = sel_onehot(r_sel);
`ifdef FIXED_PRIO_EN
            w_ptr_nxt   = '0;
`else
            w_ptr_nxt   = r_sel + SEL_W'(1);
`endif
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // out_valid is always high here, so out_ready alone completes it
            if (bus.out_ready) begin
               w_valid_nxt = 1'b0;
               if (w_any) begin
                  w_sel_nxt   = w_winner;
                  w_state_nxt = ST_CAPTURE;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // datapath registers; reset drops any in-flight beat without a gnt
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr   <= PTR_INIT;
         r_sel   <= '0;
         r_gnt   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_ptr   <= w_ptr_nxt;
         r_sel   <= w_sel_nxt;
         r_gnt   <= w_gnt_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign bus.sel       = r_sel;
   assign bus.gnt       = r_gnt;
   assign bus.out_data  = r_data;
   assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// Bench for mux_rr_sequencer: channel requesters and a 4x1 mux model
// drive the DUT; a transaction-level model predicts each served beat and
// a monitor compares grants and handshaken data against the prediction.
module tb_mux_rr_sequencer;
   import mux_rr_sequencer_pkg::*;

   localparam int DW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux_rr_sequencer_if #(.DATA_W(DW)) bus ();

   logic [DW-1:0] ch_data [NUM_CH];
   assign bus.mux_out = ch_data[bus.sel];

   mux_rr_sequencer #(.DATA_W(DW), .PTR_RST(2'd0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   int            exp_gnt_q [$];
   logic [DW-1:0] exp_data_q[$];

   // transaction model: a beat is in flight from arbitration until handshake
   int m_ptr;
   bit m_inflight, m_presented;

   bit pend [NUM_CH];
   bit gen_en, mode_rr, force_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // advance the model across the coming posedge using the inputs now driven
   task automatic model_edge();
      bit hs;
      int ch;
      if (rst) begin
         m_inflight  = 1'b0;
         m_presented = 1'b0;
         m_ptr       = 0;
         exp_gnt_q.delete();
         exp_data_q.delete();
         return;
      end
      hs = m_inflight && m_presented && bus.out_ready;
      if (m_inflight && !m_presented) m_presented = 1'b1;
      else if (hs)                    m_inflight  = 1'b0;
      if (!m_inflight && bus.req != 4'b0000) begin
         ch = -1;
         for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (m_ptr + k) % NUM_CH;
            if (ch < 0 && bus.req[c]) ch = c;
         end
         exp_gnt_q.push_back(ch);
         exp_data_q.push_back(ch_data[ch]);
         m_inflight  = 1'b1;
         m_presented = 1'b0;
`ifdef FIXED_PRIO_EN
         m_ptr = 0;
`else
         m_ptr = (ch + 1) % NUM_CH;
`endif
      end
   endtask

   // requesters + downstream: react to gnt, raise new requests, pick ready
   task automatic drive();
      logic [NUM_CH-1:0] g;
      g = bus.gnt;
      for (int i = 0; i < NUM_CH; i++) begin
         if (g[i]) begin
            pend[i]    = 1'b0;
            bus.req[i] = 1'b0;
         end
         if (!pend[i] && gen_en) begin
            if (mode_rr) begin
               pend[i] = 1'b1; ch_data[i] = DW'(i + 1); bus.req[i] = 1'b1;
            end else if ($urandom_range(0, 2) == 0) begin
`ifdef FIXED_PRIO_EN
               if (i == 1 || i == 3) begin
`else
               begin
`endif
                  pend[i] = 1'b1; ch_data[i] = DW'($urandom); bus.req[i] = 1'b1;
               end
            end
         end
      end
      if (mode_rr || force_ready) bus.out_ready = 1'b1;
      else                        bus.out_ready = ($urandom_range(0, 3) != 0);
      model_edge();
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         drive();
      end
   endtask

   // monitor: compare gnt pulses and handshaken beats, check stall rules
   int  cyc = 0, last_hs = 0;
   bit  last_hs_ok = 1'b0;
   bit  pv = 1'b0, pr = 1'b0, prst = 1'b1;
   logic [DW-1:0]    pdata;
   logic [SEL_W-1:0] psel;
   initial begin
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (bus.gnt != 4'b0000) begin
            if (exp_gnt_q.size() == 0) check("gnt_unexpected", 32'(bus.gnt), 32'h0);
            else check("gnt", 32'(bus.gnt), 32'(sel_onehot(SEL_W'(exp_gnt_q.pop_front()))));
         end
         if (!pv && bus.out_valid) check("gnt_with_valid", 32'(bus.gnt != 4'b0000), 32'h1);
         if (pv && !pr && !prst) begin
            check("valid_hold", 32'(bus.out_valid), 32'h1);
            check("data_hold", 32'(bus.out_data), 32'(pdata));
            check("sel_hold", 32'(bus.sel), 32'(psel));
         end
         if (!mode_rr) last_hs_ok = 1'b0;
         if (bus.out_valid && bus.out_ready && !rst) begin
            if (exp_data_q.size() == 0) check("beat_unexpected", 32'(bus.out_data), 32'hFFFF);
            else check("out_data", 32'(bus.out_data), 32'(exp_data_q.pop_front()));
            if (mode_rr && last_hs_ok) check("beat_spacing", 32'(cyc - last_hs), 32'd2);
            last_hs    = cyc;
            last_hs_ok = mode_rr;
         end
         pv = bus.out_valid; pr = bus.out_ready; prst = rst;
         pdata = bus.out_data; psel = bus.sel;
      end
   end

   task automatic drain(input string name);
      bit idle;
      gen_en = 1'b0; force_ready = 1'b1;
      idle = 1'b0;
      for (int n = 0; n < 200 && !idle; n++) begin
         step(1);
         idle = (exp_data_q.size() == 0) && !bus.out_valid && (bus.req == 4'b0000);
      end
      check({name, "_idle"}, 32'(idle), 32'h1);
      check({name, "_gnt_q"}, 32'(exp_gnt_q.size()), 32'h0);
   endtask

   initial begin
      bit hit;
      for (int i = 0; i < NUM_CH; i++) begin pend[i] = 1'b0; ch_data[i] = '0; end
      gen_en = 1'b0; mode_rr = 1'b0; force_ready = 1'b0;
      rst = 1'b1; bus.req = 4'b1111; bus.out_ready = 1'b0;
      model_edge();

      // reset held with all channels requesting: outputs stay zero
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         check("reset_outs", 32'({bus.sel, bus.gnt, bus.out_valid, bus.out_data}), 32'h0);
      end
      rst = 1'b0; bus.req = 4'b0000; bus.out_ready = 1'b1;
      model_edge();

      // single request from ch2
      @(negedge clk);
      ch_data[2] = 4'hA; pend[2] = 1'b1; bus.req = 4'b0100; bus.out_ready = 1'b1;
      force_ready = 1'b1;
      model_edge();
      @(negedge clk);
      check("single_sel", 32'(bus.sel), 32'd2);
      drive();
      step(4);
      drain("single");

      // all channels requesting, downstream always ready
      mode_rr = 1'b1; gen_en = 1'b1;
      step(24);
      mode_rr = 1'b0;
      drain("rr");

      // randomized traffic with random backpressure
      gen_en = 1'b1; force_ready = 1'b0;
      step(500);

      // stall an output, then reset in the middle of the wait
      force_ready = 1'b0;
      bus.out_ready = 1'b0;
      hit = 1'b0;
      for (int n = 0; n < 60 && !hit; n++) begin
         @(negedge clk);
         if (bus.out_valid && bus.gnt == 4'b0000) begin
            hit = 1'b1;
            rst = 1'b1; bus.out_ready = 1'b0;
            model_edge();
         end else begin
            drive();
            bus.out_ready = 1'b0;
            m_presented = m_presented;
         end
      end
      check("midwait_reached", 32'(hit), 32'h1);
      @(negedge clk);
      check("midwait_reset_outs", 32'({bus.sel, bus.gnt, bus.out_valid}), 32'h0);
      rst = 1'b0;
      drive();

      step(300);
      drain("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
